axilite_slave_regs: RTL and testbench



---
 rtl/axilite_slave_regs.sv | 240 ++++++++++++++++++++++++
 tb/tb_axilite_slave_regs.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_slave_regs.sv
// axilite_slave_regs: AXI4-Lite slave register file for the action-side MMIO path.
// Register map: 0x00 CONTROL (START, IRQ_EN), 0x04 STATUS (BUSY, sticky DONE),
// 0x08 and up user registers with byte strobes. Out-of-range indices give SLVERR.
// Optional feature macro: AXILITE_SLAVE_IRQ_EN builds the IRQ_EN bit and the irq flop.
`timescale 1ns/1ps
module axilite_slave_regs #(
    parameter int ADDR_W   = 12,
    parameter int NUM_REGS = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [ADDR_W-1:0]            s_axi_awaddr,
    input  logic [2:0]                   s_axi_awprot,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [31:0]                  s_axi_wdata,
    input  logic [3:0]                   s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [ADDR_W-1:0]            s_axi_araddr,
    input  logic [2:0]                   s_axi_arprot,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [31:0]                  s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic                         act_start,
    input  logic                         act_busy,
    input  logic                         act_done,
    output logic [(NUM_REGS-2)*32-1:0]   user_regs,
    output logic                         irq
);
    localparam int         IDX_W       = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_GOTA, W_GOTW, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    w_state_t                  w_state, w_next;
    r_state_t                  r_state, r_next;
    logic                      out_of_reset;
    logic                      aw_hs, w_hs, ar_hs, wr_commit;
    logic [ADDR_W-1:0]         aw_addr_q, wr_addr;
    logic [31:0]               w_data_q, wr_data, rd_word;
    logic [3:0]                w_strb_q, wr_strb;
    logic [IDX_W-1:0]          wr_idx, rd_idx;
    logic                      wr_ok, rd_ok, status_rd;
    logic [NUM_REGS-3:0][31:0] user_q;
    logic                      done_q, irq_en_rd;
    logic                      unused_ok;

    // Readies stay low until the first edge after reset release.
    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) out_of_reset <= 1'b0;
        else         out_of_reset <= 1'b1;
    end

    // Write FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) w_state <= W_IDLE;
        else         w_state <= w_next;
    end

    // Write FSM next state, readies and commit strobe.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        wr_commit     = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = out_of_reset;
                s_axi_wready  = out_of_reset;
                if (out_of_reset && s_axi_awvalid && s_axi_wvalid) begin
                    wr_commit = 1'b1;
                    w_next    = W_RESP;
                end else if (out_of_reset && s_axi_awvalid) begin
                    w_next = W_GOTA;
                end else if (out_of_reset && s_axi_wvalid) begin
                    w_next = W_GOTW;
                end
            end
            W_GOTA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    wr_commit = 1'b1;
                    w_next    = W_RESP;
                end
            end
            W_GOTW: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) begin
                    wr_commit = 1'b1;
                    w_next    = W_RESP;
                end
            end
            W_RESP: if (s_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    assign aw_hs        = s_axi_awvalid & s_axi_awready;
    assign w_hs         = s_axi_wvalid & s_axi_wready;
    assign s_axi_bvalid = (w_state == W_RESP);

    // Hold whichever half of the write arrived first.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (aw_hs) aw_addr_q <= s_axi_awaddr;
            if (w_hs) begin
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
        end
    end

    assign wr_addr = (w_state == W_GOTA) ? aw_addr_q : s_axi_awaddr;
    assign wr_data = (w_state == W_GOTW) ? w_data_q  : s_axi_wdata;
    assign wr_strb = (w_state == W_GOTW) ? w_strb_q  : s_axi_wstrb;
    assign wr_idx  = wr_addr[ADDR_W-1:2];
    assign wr_ok   = int'(wr_idx) < NUM_REGS;

    // Commit writes: user registers per byte, start pulse, write response code.
    // NOTE: the register array is reset because software expects every register to read 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            user_q      <= '0;
            act_start   <= 1'b0;
            s_axi_bresp <= RESP_OKAY;
        end else begin
            act_start <= 1'b0;
            if (wr_commit) begin
                s_axi_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_idx == '0) act_start <= wr_strb[0] & wr_data[0];
                for (int k = 0; k < NUM_REGS - 2; k++) begin
                    if (int'(wr_idx) == k + 2) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wr_strb[b]) user_q[k][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    assign user_regs = user_q;

    // Read FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= R_IDLE;
        else         r_state <= r_next;
    end

    // Read FSM next state and address ready.
    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = out_of_reset;
                if (out_of_reset && s_axi_arvalid) r_next = R_DATA;
            end
            R_DATA: if (s_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_hs        = s_axi_arvalid & s_axi_arready;
    assign s_axi_rvalid = (r_state == R_DATA);
    assign rd_idx       = s_axi_araddr[ADDR_W-1:2];
    assign rd_ok        = int'(rd_idx) < NUM_REGS;
    assign status_rd    = ar_hs & (rd_idx == IDX_W'(1));

    // Read mux over pre-edge register values; out-of-range indices read 0.
    always_comb begin
        rd_word = '0;
        if (rd_idx == '0) begin
            rd_word = {30'd0, irq_en_rd, 1'b0};
        end else if (rd_idx == IDX_W'(1)) begin
            rd_word = {30'd0, done_q, act_busy};
        end else begin
            for (int k = 0; k < NUM_REGS - 2; k++) begin
                if (int'(rd_idx) == k + 2) rd_word = user_q[k];
            end
        end
    end

    // Capture read data and response at the AR handshake; held until rready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axi_rdata <= rd_word;
            s_axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Sticky DONE: a new done pulse wins over a same-edge clear-on-read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) done_q <= 1'b0;
        else         done_q <= act_done | (done_q & ~status_rd);
    end

`ifdef AXILITE_SLAVE_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    // IRQ_EN control bit, written through byte lane 0 of CONTROL.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                      irq_en_q <= 1'b0;
        else if (wr_commit && wr_idx == '0 && wr_strb[0]) irq_en_q <= wr_data[1];
    end

    // Registered interrupt level, one cycle behind DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) irq_q <= 1'b0;
        else         irq_q <= irq_en_q & done_q;
    end

    assign irq       = irq_q;
    assign irq_en_rd = irq_en_q;
`else
    assign irq       = 1'b0;
    assign irq_en_rd = 1'b0;
`endif

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], s_axi_araddr[1:0]};
endmodule

// File: tb/tb_axilite_slave_regs.sv
// tb_axilite_slave_regs: directed scoreboard bench for axilite_slave_regs.
// Expected B/R responses are queued at issue time and checked by monitors on handshake.
`timescale 1ns/1ps
module tb_axilite_slave_regs;
    localparam int         ADDR_W   = 12;
    localparam int         NUM_REGS = 16;
    localparam logic [1:0] OKAY     = 2'b00;
    localparam logic [1:0] SLVERR   = 2'b10;
`ifdef AXILITE_SLAVE_IRQ_EN
    localparam logic       IRQ_ON   = 1'b1;
`else
    localparam logic       IRQ_ON   = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       resetn = 1'b1;
    logic [ADDR_W-1:0]          s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [2:0]                 s_axi_awprot = '0, s_axi_arprot = '0;
    logic                       s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
    logic [31:0]                s_axi_wdata = '0;
    logic [3:0]                 s_axi_wstrb = '0;
    logic                       s_axi_bready = 1'b1, s_axi_rready = 1'b1;
    logic                       act_busy = 1'b0, act_done = 1'b0;
    logic                       s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]                 s_axi_bresp, s_axi_rresp;
    logic [31:0]                s_axi_rdata;
    logic                       act_start, irq;
    logic [(NUM_REGS-2)*32-1:0] user_regs;

    axilite_slave_regs #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .act_start(act_start), .act_busy(act_busy),
        .act_done(act_done), .user_regs(user_regs), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    int         checks    = 0;
    int         errors    = 0;
    int         start_cnt = 0;
    logic [1:0] b_q[$];
    r_exp_t     r_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake never completed within the cycle budget", name);
    endtask

    // Write-response monitor.
    always @(negedge clk) begin
        if (resetn && s_axi_bvalid && s_axi_bready) begin
            if (b_q.size() == 0) fail_now("b_unexpected");
            else check("bresp", {30'd0, s_axi_bresp}, {30'd0, b_q.pop_front()});
        end
    end

    // Read-data monitor.
    always @(negedge clk) begin
        r_exp_t e;
        if (resetn && s_axi_rvalid && s_axi_rready) begin
            if (r_q.size() == 0) begin
                fail_now("r_unexpected");
            end else begin
                e = r_q.pop_front();
                check("rdata", s_axi_rdata, e.data);
                check("rresp", {30'd0, s_axi_rresp}, {30'd0, e.resp});
            end
        end
    end

    always @(negedge clk) if (act_start) start_cnt++;

    // Called at a falling edge; returns one step after the completing rising edge.
    task automatic wait_b();
        int n = 0;
        while (!(s_axi_bvalid && s_axi_bready)) begin
            if (++n > 32) begin fail_now("b_wait"); return; end
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_r();
        int n = 0;
        while (!(s_axi_rvalid && s_axi_rready)) begin
            if (++n > 32) begin fail_now("r_wait"); return; end
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] resp);
        int n = 0;
        bit aw_hs, w_hs;
        b_q.push_back(resp);
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        while (s_axi_awvalid || s_axi_wvalid) begin
            @(negedge clk);
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            @(posedge clk); #1;
            if (aw_hs) s_axi_awvalid = 1'b0;
            if (w_hs)  s_axi_wvalid  = 1'b0;
            if (++n > 20) begin
                fail_now("aw_w_wait");
                s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
            end
        end
        @(negedge clk);
        check("b_latency", {31'd0, s_axi_bvalid}, 32'd1);
        wait_b();
    endtask

    task automatic axi_read(input logic [11:0] a, input logic [31:0] d,
                            input logic [1:0] resp, input bit pulse_done);
        int n = 0;
        bit hs;
        r_q.push_back('{data: d, resp: resp});
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        if (pulse_done) act_done = 1'b1;
        while (s_axi_arvalid) begin
            @(negedge clk);
            hs = s_axi_arvalid && s_axi_arready;
            @(posedge clk); #1;
            if (pulse_done) act_done = 1'b0;
            if (hs) s_axi_arvalid = 1'b0;
            if (++n > 20) begin fail_now("ar_wait"); s_axi_arvalid = 1'b0; end
        end
        @(negedge clk);
        check("r_latency", {31'd0, s_axi_rvalid}, 32'd1);
        wait_r();
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        // Reset state, including readies held low across clock edges.
        #1 resetn = 1'b0;
        #2;
        check("rst_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
        check("rst_valids", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        check("rst_start_irq", {30'd0, act_start, irq}, 32'd0);
        repeat (2) @(posedge clk);
        #1 check("rst_readies_clocked", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
        @(negedge clk); #2 resetn = 1'b1;
        #1 check("ready_before_edge", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
        @(posedge clk); #1;
        check("ready_after_edge", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);

        // AW and W together, full strobe.
        axi_write(12'h008, 32'hA5A5_1234, 4'hF, OKAY);
        axi_read(12'h008, 32'hA5A5_1234, OKAY, 1'b0);
        check("user_reg2", user_regs[0 +: 32], 32'hA5A5_1234);

        // W three cycles before AW, single byte lane, late bready.
        axi_write(12'h00C, 32'h1122_3344, 4'hF, OKAY);
        s_axi_bready = 1'b0;
        s_axi_wdata = 32'h0000_7700; s_axi_wstrb = 4'b0010; s_axi_wvalid = 1'b1;
        @(negedge clk);
        check("w_only_ready", {31'd0, s_axi_wready}, 32'd1);
        @(posedge clk); #1 s_axi_wvalid = 1'b0;
        @(negedge clk);
        check("gotw_wready_low", {31'd0, s_axi_wready}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_q.push_back(OKAY);
        s_axi_awaddr = 12'h00C; s_axi_awvalid = 1'b1;
        @(negedge clk);
        check("gotw_awready", {30'd0, s_axi_awready, s_axi_bvalid}, 32'd2);
        @(posedge clk); #1 s_axi_awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b_hold", {29'd0, s_axi_bvalid, s_axi_bresp}, 32'h4);
        end
        @(posedge clk); #1 s_axi_bready = 1'b1;
        @(negedge clk);
        wait_b();
        axi_read(12'h00C, 32'h1122_7744, OKAY, 1'b0);
        check("user_reg3", user_regs[32 +: 32], 32'h1122_7744);

        // START pulse, IRQ_EN, DONE and irq.
        axi_write(12'h000, 32'h0000_0001, 4'hF, OKAY);
        repeat (3) @(posedge clk);
        #1 check("start_pulse_count", start_cnt, 32'd1);
        axi_read(12'h000, 32'h0, OKAY, 1'b0);
        axi_write(12'h000, 32'h0000_0002, 4'hF, OKAY);
        axi_read(12'h000, IRQ_ON ? 32'h2 : 32'h0, OKAY, 1'b0);
        check("start_only_on_bit0", start_cnt, 32'd1);
        act_done = 1'b1;
        @(posedge clk); #1 act_done = 1'b0;
        @(negedge clk);
        check("irq_lag", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, {31'd0, IRQ_ON});
        @(posedge clk); #1;
        axi_read(12'h004, 32'h2, OKAY, 1'b0);
        axi_read(12'h004, 32'h0, OKAY, 1'b0);
        @(negedge clk);
        check("irq_fall", {31'd0, irq}, 32'd0);
        @(posedge clk); #1 act_busy = 1'b1;
        axi_read(12'h004, 32'h1, OKAY, 1'b0);
        act_busy = 1'b0;

        // Out-of-range, last valid index, read-only STATUS.
        axi_write(12'h040, 32'hFFFF_FFFF, 4'hF, SLVERR);
        axi_read(12'h040, 32'h0, SLVERR, 1'b0);
        axi_write(12'hFFC, 32'h5555_5555, 4'hF, SLVERR);
        axi_read(12'h008, 32'hA5A5_1234, OKAY, 1'b0);
        axi_read(12'h03C, 32'h0, OKAY, 1'b0);
        axi_write(12'h03F, 32'hAABB_CCDD, 4'b1001, OKAY);
        axi_read(12'h03C, 32'hAA00_00DD, OKAY, 1'b0);
        check("user_reg15", user_regs[13*32 +: 32], 32'hAA00_00DD);
        axi_write(12'h004, 32'hFFFF_FFFF, 4'hF, OKAY);
        axi_read(12'h004, 32'h0, OKAY, 1'b0);

        // act_done on the same edge as a STATUS read.
        axi_read(12'h004, 32'h0, OKAY, 1'b1);
        axi_read(12'h004, 32'h2, OKAY, 1'b0);
        axi_read(12'h004, 32'h0, OKAY, 1'b0);

        // Read and write of the same register on the same edge.
        fork
            axi_write(12'h010, 32'hDEAD_BEEF, 4'hF, OKAY);
            axi_read(12'h010, 32'h0, OKAY, 1'b0);
        join
        axi_read(12'h010, 32'hDEAD_BEEF, OKAY, 1'b0);

        // Reset asserted while both responses are pending.
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        s_axi_awaddr = 12'h008; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        s_axi_araddr = 12'h008; s_axi_arvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        @(negedge clk);
        check("pending_valids", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd3);
        #2 resetn = 1'b0;
        #1;
        check("async_valids", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
        check("async_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
        check("async_rdata", s_axi_rdata, 32'd0);
        check("async_user_regs", {31'd0, |user_regs}, 32'd0);
        @(negedge clk); #2 resetn = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            axi_read(12'(i * 4), 32'h0, OKAY, 1'b0);
        end

        check("b_queue_empty", b_q.size(), 32'd0);
        check("r_queue_empty", r_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
